// File: rtl/ht_vertical.sv
// Vertical 8-point Hadamard stage: buffers eight horizontal-transform rows, then emits one transformed column per beat.
// Optional HT_VERTICAL_PINGPONG_EN: two banks so one fills while the other drains.
module ht_vertical #(
  parameter int WIDTH   = 8,
  parameter int SAMPLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH+4:0] hth_0,
  input  logic signed [WIDTH+4:0] hth_1,
  input  logic signed [WIDTH+4:0] hth_2,
  input  logic signed [WIDTH+4:0] hth_3,
  input  logic signed [WIDTH+4:0] hth_4,
  input  logic signed [WIDTH+4:0] hth_5,
  input  logic signed [WIDTH+4:0] hth_6,
  input  logic signed [WIDTH+4:0] hth_7,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH+7:0] htv_0,
  output logic signed [WIDTH+7:0] htv_1,
  output logic signed [WIDTH+7:0] htv_2,
  output logic signed [WIDTH+7:0] htv_3,
  output logic signed [WIDTH+7:0] htv_4,
  output logic signed [WIDTH+7:0] htv_5,
  output logic signed [WIDTH+7:0] htv_6,
  output logic signed [WIDTH+7:0] htv_7,
  output logic                    out_last,
  output logic [1:0]              dbg_state
);

  localparam int IW = WIDTH + 5;
  localparam int OW = WIDTH + 8;
  localparam logic [2:0] LAST = 3'(SAMPLES - 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and data is held stable while valid is high and ready is low.

  logic signed [IW-1:0] hth_a [SAMPLES];
  logic signed [IW-1:0] col_v [SAMPLES];
  logic signed [OW-1:0] htv_a [SAMPLES];
  logic signed [OW-1:0] term;

  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic       wr_en;

  assign hth_a[0] = hth_0;
  assign hth_a[1] = hth_1;
  assign hth_a[2] = hth_2;
  assign hth_a[3] = hth_3;
  assign hth_a[4] = hth_4;
  assign hth_a[5] = hth_5;
  assign hth_a[6] = hth_6;
  assign hth_a[7] = hth_7;

`ifdef HT_VERTICAL_PINGPONG_EN
  logic signed [IW-1:0] mem_q [2][SAMPLES][SAMPLES];
  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      row_q     <= 3'd0;
      col_q     <= 3'd0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      row_q     <= row_d;
      col_q     <= col_d;
    end
  end

  // Banks fill and drain in strict alternation, so the write bank being full means both are full.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    row_d     = row_q;
    col_d     = col_q;
    in_ready  = ~full_q[wr_bank_q];
    out_valid = full_q[rd_bank_q];
    wr_en     = in_valid & ~full_q[wr_bank_q];
    if (wr_en) begin
      row_d = row_q + 3'd1;
      if (row_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (out_valid && out_ready) begin
      col_d = col_q + 3'd1;
      if (col_q == LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < SAMPLES; j++) mem_q[wr_bank_q][row_q][j] <= hth_a[j];
    end
  end

  always_comb begin
    for (int r = 0; r < SAMPLES; r++) col_v[r] = mem_q[rd_bank_q][r][col_q];
  end

  assign dbg_state = full_q;
`else
  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  logic signed [IW-1:0] mem_q [SAMPLES][SAMPLES];
  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
          row_d = row_q + 3'd1;
          if (row_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          col_d = col_q + 3'd1;
          if (col_q == LAST) state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < SAMPLES; j++) mem_q[row_q][j] <= hth_a[j];
    end
  end

  always_comb begin
    for (int r = 0; r < SAMPLES; r++) col_v[r] = mem_q[r][col_q];
  end

  assign dbg_state = {1'b0, state_q};
`endif

  assign out_last = out_valid & (col_q == LAST);

  // Sylvester-order Hadamard: sign of row r in coefficient k is the parity of (k & r).
  always_comb begin
    term = '0;
    for (int k = 0; k < SAMPLES; k++) begin
      htv_a[k] = '0;
      for (int r = 0; r < SAMPLES; r++) begin
        term = {{(OW - IW){col_v[r][IW-1]}}, col_v[r]};
        if (^(3'(k) & 3'(r))) htv_a[k] = htv_a[k] - term;
        else                  htv_a[k] = htv_a[k] + term;
      end
    end
  end

  assign htv_0 = htv_a[0];
  assign htv_1 = htv_a[1];
  assign htv_2 = htv_a[2];
  assign htv_3 = htv_a[3];
  assign htv_4 = htv_a[4];
  assign htv_5 = htv_a[5];
  assign htv_6 = htv_a[6];
  assign htv_7 = htv_a[7];

endmodule

// File: tb/tb_ht_vertical.sv
// Self-checking bench for ht_vertical: table vectors, hand-written corner sequences and
// random blocks scored against a matrix-product Hadamard model.
module tb_ht_vertical;

  localparam int WIDTH = 8;
  localparam int IW    = WIDTH + 5;
  localparam int OW    = WIDTH + 8;
  localparam int EW    = 8 * OW + 1;
  localparam int RW    = 8 * IW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [IW-1:0] hth_0 = '0, hth_1 = '0, hth_2 = '0, hth_3 = '0;
  logic signed [IW-1:0] hth_4 = '0, hth_5 = '0, hth_6 = '0, hth_7 = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [OW-1:0] htv_0, htv_1, htv_2, htv_3, htv_4, htv_5, htv_6, htv_7;
  logic                 out_last;
  logic [1:0]           dbg_state;

  ht_vertical #(.WIDTH(WIDTH), .SAMPLES(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .hth_0(hth_0), .hth_1(hth_1), .hth_2(hth_2), .hth_3(hth_3),
    .hth_4(hth_4), .hth_5(hth_5), .hth_6(hth_6), .hth_7(hth_7),
    .out_valid(out_valid), .out_ready(out_ready),
    .htv_0(htv_0), .htv_1(htv_1), .htv_2(htv_2), .htv_3(htv_3),
    .htv_4(htv_4), .htv_5(htv_5), .htv_6(htv_6), .htv_7(htv_7),
    .out_last(out_last), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int ready_drops = 0;
  logic [EW-1:0] exp_q[$];
  logic [RW-1:0] pend_q[$];
  int blk[8][8];
  int hm[8][8];

  typedef struct {
    int mode;
    int val;
    int mask;
    int exp[8];
  } vec_t;
  vec_t vt[7];

  function automatic logic [EW-1:0] dut_word();
    return {out_last, htv_7, htv_6, htv_5, htv_4, htv_3, htv_2, htv_1, htv_0};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp_v);
    end
  endtask

  // Sylvester construction: H(2n) = [[H, H], [H, -H]].
  task automatic build_hadamard();
    hm[0][0] = 1;
    for (int n = 1; n < 8; n = n * 2)
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++) begin
          hm[i][j + n]     = hm[i][j];
          hm[i + n][j]     = hm[i][j];
          hm[i + n][j + n] = -hm[i][j];
        end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_row(input logic [RW-1:0] row);
    hth_0 = row[0*IW +: IW]; hth_1 = row[1*IW +: IW];
    hth_2 = row[2*IW +: IW]; hth_3 = row[3*IW +: IW];
    hth_4 = row[4*IW +: IW]; hth_5 = row[5*IW +: IW];
    hth_6 = row[6*IW +: IW]; hth_7 = row[7*IW +: IW];
  endtask

  // mode 0: constant, 1: row index * val, 2: val * (-1)^popcount(r & mask), 3: column index * val, else random
  task automatic load_rows(input int mode, input int val, input int mask);
    logic [RW-1:0] row;
    int v;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        case (mode)
          0: v = val;
          1: v = r * val;
          2: v = ($countones(r & mask) % 2 == 1) ? -val : val;
          3: v = c * val;
          default: v = int'($urandom_range(8191)) - 4096;
        endcase
        blk[r][c] = v;
        row[c*IW +: IW] = v[IW-1:0];
      end
      pend_q.push_back(row);
    end
  endtask

  task automatic push_model_expect();
    logic [EW-1:0] e;
    int s;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 8; k++) begin
        s = 0;
        for (int r = 0; r < 8; r++) s += hm[k][r] * blk[r][c];
        e[k*OW +: OW] = s[OW-1:0];
      end
      e[EW-1] = (c == 7);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_table_expect(input vec_t tv);
    logic [EW-1:0] e;
    int s;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 8; k++) begin
        s = tv.exp[k];
        e[k*OW +: OW] = s[OW-1:0];
      end
      e[EW-1] = (c == 7);
      exp_q.push_back(e);
    end
  endtask

  // Called at the negedge: a beat seen here transfers at the following posedge.
  task automatic observe();
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat got=%h expected=none", dut_word());
      end else begin
        check("beat", dut_word(), exp_q.pop_front());
      end
    end
  endtask

  task automatic drain_all(input int ready_pct, input int budget);
    int cyc = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(posedge clk); #1;
      in_valid = (pend_q.size() > 0);
      if (pend_q.size() > 0) drive_row(pend_q[0]);
      out_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      observe();
      if (in_valid && !in_ready) ready_drops++;
      if (in_valid && in_ready) void'(pend_q.pop_front());
      cyc++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (cyc >= budget) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got=%0d_pending expected=0", exp_q.size());
      exp_q.delete();
      pend_q.delete();
    end
  endtask

  task automatic fill_only(input int budget);
    int cyc = 0;
    out_ready = 1'b0;
    while (pend_q.size() > 0 && cyc < budget) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      drive_row(pend_q[0]);
      @(negedge clk);
      if (in_ready) void'(pend_q.pop_front());
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (cyc >= budget) begin
      total++;
      bad++;
      $display("FAIL fill_timeout got=%0d_rows expected=0", pend_q.size());
      pend_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] snap;
    logic [RW-1:0] row;
    int nb, st, s, seven;
    bit hs;

    vt[0] = '{0, 1,     0, '{8, 0, 0, 0, 0, 0, 0, 0}};
    vt[1] = '{1, 1,     0, '{28, -4, -8, 0, -16, 0, 0, 0}};
    vt[2] = '{0, -4096, 0, '{-32768, 0, 0, 0, 0, 0, 0, 0}};
    vt[3] = '{0, 4095,  0, '{32760, 0, 0, 0, 0, 0, 0, 0}};
    vt[4] = '{2, 3,     1, '{0, 24, 0, 0, 0, 0, 0, 0}};
    vt[5] = '{2, -5,    6, '{0, 0, 0, 0, 0, 0, -40, 0}};
    vt[6] = '{2, 100,   7, '{0, 0, 0, 0, 0, 0, 0, 800}};

    build_hadamard();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_in_ready",  EW'(in_ready),  EW'(1'b1));
    check("rst_out_valid", EW'(out_valid), EW'(1'b0));
    check("rst_out_last",  EW'(out_last),  EW'(1'b0));
    check("rst_dbg_state", EW'(dbg_state), EW'(2'b00));

    for (int i = 0; i < 7; i++) begin
      load_rows(vt[i].mode, vt[i].val, vt[i].mask);
      push_table_expect(vt[i]);
      drain_all((i % 2 == 1) ? 60 : 100, 400);
    end

    // Latency and stall: column-index block, htv_0 = 8*c, all else 0.
    for (int r = 0; r < 8; r++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 8; c++) begin
        s = c;
        row[c*IW +: IW] = s[IW-1:0];
      end
      in_valid  = 1'b1;
      out_ready = 1'b0;
      drive_row(row);
      @(negedge clk);
      if (r == 7) check("pre_latency_valid", EW'(out_valid), EW'(1'b0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_valid", EW'(out_valid), EW'(1'b1));
`ifndef HT_VERTICAL_PINGPONG_EN
    check("drain_in_ready", EW'(in_ready), EW'(1'b0));
`endif
    for (int c = 0; c < 8; c++) begin
      e = '0;
      s = 8 * c;
      e[0 +: OW] = s[OW-1:0];
      e[EW-1] = (c == 7);
      exp_q.push_back(e);
    end
    nb = 0;
    st = 0;
    snap = '0;
    seven = 7;
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      @(posedge clk); #1;
      if (nb == 2 && st < 3) begin
        out_ready = 1'b0;
`ifndef HT_VERTICAL_PINGPONG_EN
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) row[c*IW +: IW] = seven[IW-1:0];
        drive_row(row);
`endif
      end else begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      @(negedge clk);
      if (!out_ready) begin
        if (st == 0) snap = dut_word();
        else check("stall_hold", dut_word(), snap);
`ifndef HT_VERTICAL_PINGPONG_EN
        check("stall_in_ready", EW'(in_ready), EW'(1'b0));
`endif
        st++;
      end
      hs = (out_valid === 1'b1) && out_ready;
      observe();
      if (hs) nb++;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("stall_beat_count", EW'(nb), EW'(8));
    @(negedge clk);
    check("post_drain_in_ready",  EW'(in_ready),  EW'(1'b1));
    check("post_drain_out_valid", EW'(out_valid), EW'(1'b0));

    // Reset in the middle of a drain discards the remaining columns.
    load_rows(3, 1, 0);
    push_model_expect();
    fill_only(40);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      observe();
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_out_valid", EW'(out_valid), EW'(1'b0));
    check("mid_rst_in_ready",  EW'(in_ready),  EW'(1'b1));
    observe();
    load_rows(vt[0].mode, vt[0].val, vt[0].mask);
    push_table_expect(vt[0]);
    drain_all(100, 400);

    // Random blocks against the matrix-product model.
    for (int round = 0; round < 3; round++) begin
      for (int b = 0; b < 3; b++) begin
        load_rows(9, 0, 0);
        push_model_expect();
      end
      drain_all(40 + 30 * round, 3000);
    end

`ifdef HT_VERTICAL_PINGPONG_EN
    ready_drops = 0;
    load_rows(vt[0].mode, vt[0].val, vt[0].mask);
    push_table_expect(vt[0]);
    load_rows(vt[1].mode, vt[1].val, vt[1].mask);
    push_table_expect(vt[1]);
    drain_all(100, 400);
    check("pp_in_ready_drops", EW'(ready_drops), EW'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ht_vertical.md
HT_VERTICAL -- requirements
Module: ht_vertical

Interface
REQ-001 Parameter WIDTH, default 8, is the pixel sample width; input words are WIDTH+5 bits and output words are WIDTH+8 bits.
REQ-002 Parameter SAMPLES, default 8, is the transform size; only the value 8 is supported.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  a horizontal-transform row is present on hth_0..hth_7.
REQ-006 in_ready  output  1  the block accepts a row this cycle.
REQ-007 hth_0..hth_7  input  WIDTH+5 each, signed  one row of horizontal Hadamard coefficients, column index = suffix.
REQ-008 out_valid  output  1  htv_0..htv_7 hold one transformed column.
REQ-009 out_ready  input  1  the consumer (absolute-sum stage) takes the column this cycle.
REQ-010 htv_0..htv_7  output  WIDTH+8 each, signed  vertical transform of one column, coefficient index = suffix.
REQ-011 out_last  output  1  high with out_valid on column 7 of a block.

Function
REQ-012 A row SHALL be accepted on a rising edge where in_valid and in_ready are both 1; accepted rows SHALL be written to buffer row r, where r runs 0..7 in arrival order.
REQ-013 The FSM SHALL have the states FILL (in_ready=1, out_valid=0) and DRAIN (in_ready=0, out_valid=1).
REQ-014 FILL SHALL go to DRAIN on the edge that accepts row 7; the row counter SHALL then wrap to 0.
REQ-015 out_valid SHALL first rise in the cycle after row 7 is accepted, giving a latency of 1 cycle.
REQ-016 In DRAIN the column counter c SHALL start at 0 and advance by 1 on each edge where out_valid and out_ready are both 1.
REQ-017 DRAIN SHALL return to FILL on the handshake of c=7, and in_ready SHALL be 1 in the following cycle.
REQ-018 htv_k SHALL equal the sum over r=0..7 of (-1)^popcount(k AND r) * buf[r][c], i.e. the 8-point Sylvester-order Hadamard transform, computed exactly with sign extension and with no truncation, rounding or saturation.
REQ-019 htv_* SHALL be derived combinationally from the buffer and c, so that while out_ready=0 the outputs and c stay stable.
REQ-020 in_valid in DRAIN SHALL be ignored, and no buffer write SHALL occur.
REQ-021 out_last SHALL equal out_valid AND (c==7).

Reset
REQ-022 When rst=1 at an edge, the block SHALL set state=FILL, row counter=0, c=0, out_valid=0, out_last=0 and in_ready=1 in the next cycle.
REQ-023 Buffer contents SHALL NOT be reset; outputs are don't-care while out_valid=0.
REQ-024 rst SHALL take priority over any simultaneous handshake; a block that is partially filled or partially drained SHALL be discarded with no further out_valid for it.

Configuration
REQ-025 With macro HT_VERTICAL_PINGPONG_EN defined, two 8x8 banks SHALL be implemented: rows fill one bank while the other bank drains.
REQ-026 With HT_VERTICAL_PINGPONG_EN, in_ready SHALL be 0 only when both banks are full; drain order SHALL equal fill order.
REQ-027 With HT_VERTICAL_PINGPONG_EN, a fill completion and a drain completion on the same edge SHALL start draining the newly full bank in the next cycle, with no bubble.
REQ-028 With HT_VERTICAL_PINGPONG_EN, reset SHALL empty both banks.
REQ-029 Without the macro, a single bank and the FILL/DRAIN behaviour of REQ-013..REQ-017 SHALL apply.

Verification (WIDTH=8)
REQ-030 All 64 inputs = 1, out_ready=1: out_valid rises 1 cycle after the 8th row, then 8 beats each with htv_0=8 and htv_1..7=0; out_last on beat 8.
REQ-031 Row r, all columns = r: every column gives htv_0=28, htv_1=-4, htv_2=-8, htv_4=-16, and htv_3=htv_5=htv_6=htv_7=0.
REQ-032 All inputs = -4096: htv_0=-32768 with no wrap, and htv_1..7=0.
REQ-033 out_ready=0 for 3 cycles at c=2: htv_* and out_last stay constant, c stays 2, in_ready stays 0 (no macro), and 8 beats total.
REQ-034 rst at c=4: the next cycle has out_valid=0 and in_ready=1; 8 fresh rows of 1 then yield REQ-030 results exactly.
REQ-035 HT_VERTICAL_PINGPONG_EN, 16 back-to-back rows, out_ready=1: in_ready never drops, 16 correct beats are produced, and out_last appears on beats 8 and 16.
